// File: rtl/pe_array_16_pkg.sv
// pe_array_16_pkg
//   Shared constants and types for the 16-lane PE array.
//   - DATA_WIDTH      : operand / result width (signed Q3.12)
//   - FRAC_BITS_DEF   : default number of fractional bits
//   - ACC_W_DEF       : default accumulator width per lane
//   - PROD_W          : full-precision product width
//   - ONE_Q           : the value 1.0 in Q3.12
//   - pe_mode_e       : operation encoding driven by the layer controllers
package pe_array_16_pkg;

    localparam int DATA_WIDTH    = 16;
    localparam int FRAC_BITS_DEF = 12;
    localparam int ACC_W_DEF     = 40;
    localparam int PROD_W        = 2 * DATA_WIDTH;
    localparam int ONE_Q         = 4096;

    typedef enum logic [1:0] {
        MODE_MAC  = 2'd0,
        MODE_MUL  = 2'd1,
        MODE_ADD  = 2'd2,
        MODE_HOLD = 2'd3
    } pe_mode_e;

endpackage

// File: rtl/pe_array_16_lane.sv
// pe_lane
//   One multiply-accumulate lane: stage 1 registers mode/clear/product/
//   scaled A, stage 2 updates the accumulator and the sticky overflow flag.
//   The result is formatted combinationally from the accumulator register.
//   Optional macro PE_SATURATE_EN: saturate the result to 16 bits; when
//   undefined the result is the low 16 bits of acc >>> FRAC_BITS (wraps).
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   op_mode          : operation (pe_mode_e encoding)
//   clear_acc        : zero accumulator and overflow flag
//   in_a, in_b       : signed Q3.12 operands
//   result           : signed Q3.12 result
//   ovf              : sticky overflow flag
module pe_lane
    import pe_array_16_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            op_mode,
    input  logic                  clear_acc,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  ovf
);

    // Bits of acc above this index must all equal the result sign bit for
    // acc >>> FRAC_BITS to fit in DATA_WIDTH signed bits.
    localparam int HI_LSB = FRAC_BITS + DATA_WIDTH - 1;

    pe_mode_e                  mode_reg;
    logic                      clear_reg;
    logic signed [PROD_W-1:0]  prod_reg;
    logic signed [ACC_W-1:0]   ext_a_reg;
    logic signed [ACC_W-1:0]   acc_reg;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]   prod_ext;
    logic                      ovf_reg;
    logic                      ovf_next;
    logic [DATA_WIDTH-1:0]     r_low;

    function automatic logic out_of_range(input logic [ACC_W-1:HI_LSB] hi);
        return !((&hi) || !(|hi));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_reg  <= MODE_HOLD;
            clear_reg <= 1'b0;
            prod_reg  <= '0;
            ext_a_reg <= '0;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            mode_reg  <= pe_mode_e'(op_mode);
            clear_reg <= clear_acc;
            prod_reg  <= $signed(in_a) * $signed(in_b);
            ext_a_reg <= {{(ACC_W-DATA_WIDTH-FRAC_BITS){in_a[DATA_WIDTH-1]}},
                          in_a, {FRAC_BITS{1'b0}}};
            acc_reg   <= acc_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign prod_ext = {{(ACC_W-PROD_W){prod_reg[PROD_W-1]}}, prod_reg};

    // Clear wins over every mode; the product registered with it is dropped.
    always_comb begin
        acc_next = acc_reg;
        ovf_next = ovf_reg;
        if (clear_reg) begin
            acc_next = '0;
            ovf_next = 1'b0;
        end else begin
            case (mode_reg)
                MODE_MUL:  acc_next = prod_ext;
                MODE_MAC:  acc_next = acc_reg + prod_ext;
                MODE_ADD:  acc_next = acc_reg + ext_a_reg;
                default:   acc_next = acc_reg;
            endcase
            ovf_next = ovf_reg | out_of_range(acc_next[ACC_W-1:HI_LSB]);
        end
    end

    // Low word of the floor shift is just a slice of the accumulator.
    assign r_low = acc_reg[FRAC_BITS +: DATA_WIDTH];

`ifdef PE_SATURATE_EN
    always_comb begin
        result = r_low;
        if (out_of_range(acc_reg[ACC_W-1:HI_LSB])) begin
            result = acc_reg[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    assign result = r_low;
`endif

    assign ovf = ovf_reg;

endmodule

// File: rtl/pe_array_16.sv
// pe_array_16
//   Responder end of the PE-array interface: LANES parallel signed Q3.12
//   MAC lanes sharing one mode/clear command. Packing/unpacking only; the
//   datapath lives in pe_lane. Optional macro PE_SATURATE_EN selects
//   saturated (defined) or wrapping (undefined) result formatting.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   pe_op_mode_in     : MAC=0, MUL=1, ADD=2, HOLD=3
//   pe_clear_acc_in   : zero all accumulators and overflow flags
//   pe_in_a_vec       : operand A, lane k at [k*16 +: 16]
//   pe_in_b_vec       : operand B, same packing
//   pe_result_vec     : per-lane result, same packing
//   pe_ovf_vec        : sticky per-lane overflow flags
module pe_array_16
    import pe_array_16_pkg::*;
#(
    parameter int LANES     = 16,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  pe_op_mode_in,
    input  logic                        pe_clear_acc_in,
    input  logic [LANES*DATA_WIDTH-1:0] pe_in_a_vec,
    input  logic [LANES*DATA_WIDTH-1:0] pe_in_b_vec,
    output logic [LANES*DATA_WIDTH-1:0] pe_result_vec,
    output logic [LANES-1:0]            pe_ovf_vec
);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            pe_lane #(
                .ACC_W     (ACC_W),
                .FRAC_BITS (FRAC_BITS)
            ) u_lane (
                .clk       (clk),
                .reset     (reset),
                .op_mode   (pe_op_mode_in),
                .clear_acc (pe_clear_acc_in),
                .in_a      (pe_in_a_vec[gi*DATA_WIDTH +: DATA_WIDTH]),
                .in_b      (pe_in_b_vec[gi*DATA_WIDTH +: DATA_WIDTH]),
                .result    (pe_result_vec[gi*DATA_WIDTH +: DATA_WIDTH]),
                .ovf       (pe_ovf_vec[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pe_array_16.sv
module tb_pe_array_16;

    localparam int L = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     mode;
    logic           clr;
    logic [L*16-1:0] a_vec, b_vec;
    logic [L*16-1:0] res_vec;
    logic [L-1:0]   ovf_vec;

    int cmp_count = 0;
    int err_count = 0;

    // Reference model: two-cycle pipeline described arithmetically.
    int     m_mode;
    bit     m_clr;
    longint m_p[L];
    longint m_ea[L];
    longint m_acc[L];
    bit     m_ovf[L];

    always #5 clk = ~clk;

    pe_array_16 dut (
        .clk             (clk),
        .reset           (reset),
        .pe_op_mode_in   (mode),
        .pe_clear_acc_in (clr),
        .pe_in_a_vec     (a_vec),
        .pe_in_b_vec     (b_vec),
        .pe_result_vec   (res_vec),
        .pe_ovf_vec      (ovf_vec)
    );

    function automatic longint wrap40(input longint v);
        return (v <<< 24) >>> 24;
    endfunction

    function automatic bit fits16(input longint acc);
        longint r;
        r = acc >>> 12;
        return (r >= -32768) && (r <= 32767);
    endfunction

    function automatic logic [15:0] model_res(input longint acc);
        longint r;
        logic [63:0] rb;
        r = acc >>> 12;
`ifdef PE_SATURATE_EN
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`endif
        rb = r;
        return rb[15:0];
    endfunction

    function automatic logic [L*16-1:0] exp_res_vec();
        logic [L*16-1:0] v;
        for (int k = 0; k < L; k++) v[k*16 +: 16] = model_res(m_acc[k]);
        return v;
    endfunction

    function automatic logic [L-1:0] exp_ovf_vec();
        logic [L-1:0] v;
        for (int k = 0; k < L; k++) v[k] = m_ovf[k];
        return v;
    endfunction

    function automatic logic [L*16-1:0] splat(input logic [15:0] x);
        logic [L*16-1:0] v;
        for (int k = 0; k < L; k++) v[k*16 +: 16] = x;
        return v;
    endfunction

    function automatic logic [L*16-1:0] rand_vec();
        logic [L*16-1:0] v;
        for (int k = 0; k < L; k++) v[k*16 +: 16] = 16'($urandom);
        return v;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, and
    // leave time 1 unit after the edge for sampling.
    task automatic step(input logic rst, input logic [1:0] md, input logic c,
                        input logic [L*16-1:0] av, input logic [L*16-1:0] bv);
        longint a, b;
        reset = rst; mode = md; clr = c; a_vec = av; b_vec = bv;
        @(posedge clk);
        if (rst) begin
            m_mode = 3; m_clr = 0;
            for (int k = 0; k < L; k++) begin
                m_p[k] = 0; m_ea[k] = 0; m_acc[k] = 0; m_ovf[k] = 0;
            end
        end else begin
            for (int k = 0; k < L; k++) begin
                if (m_clr) begin
                    m_acc[k] = 0;
                    m_ovf[k] = 0;
                end else begin
                    case (m_mode)
                        0: m_acc[k] = wrap40(m_acc[k] + m_p[k]);
                        1: m_acc[k] = m_p[k];
                        2: m_acc[k] = wrap40(m_acc[k] + m_ea[k]);
                        default: ;
                    endcase
                    if (!fits16(m_acc[k])) m_ovf[k] = 1;
                end
            end
            m_mode = int'(md); m_clr = c;
            for (int k = 0; k < L; k++) begin
                a = longint'($signed(av[k*16 +: 16]));
                b = longint'($signed(bv[k*16 +: 16]));
                m_p[k]  = a * b;
                m_ea[k] = a * 4096;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 2'($urandom), 1'($urandom), rand_vec(), rand_vec());
        step(1, 2'($urandom), 1'($urandom), rand_vec(), rand_vec());
        cmp_count++;
        if (res_vec !== '0) begin
            err_count++;
            $display("FAIL reset_result: got %h want 0", res_vec);
        end
        cmp_count++;
        if (ovf_vec !== '0) begin
            err_count++;
            $display("FAIL reset_ovf: got %h want 0", ovf_vec);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 2'd3, 0, splat(16'h1000), splat(16'h1000));
            cmp_count++;
            if (res_vec !== '0) begin
                err_count++;
                $display("FAIL reset_hold[%0d]: got %h want 0", i, res_vec);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_accumulation();
        logic [L*16-1:0] bv;
        logic [15:0] want;
        for (int k = 0; k < L; k++) bv[k*16 +: 16] = 16'(k * 256);
        step(0, 2'd3, 1, '0, '0);
        for (int i = 0; i < 4; i++) step(0, 2'd0, 0, splat(16'd4096), bv);
        step(0, 2'd0, 0, '0, '0);
        for (int k = 0; k < L; k++) begin
            want = 16'(k * 1024);
            cmp_count++;
            if (res_vec[k*16 +: 16] !== want) begin
                err_count++;
                $display("FAIL accum_lane%0d: got %0d want %0d", k, res_vec[k*16 +: 16], want);
            end
        end
        step(0, 2'd0, 0, '0, '0);
        cmp_count++;
        if (res_vec !== exp_res_vec()) begin
            err_count++;
            $display("FAIL accum_zero_noop: got %h want %h", res_vec, exp_res_vec());
        end
        $display("test_accumulation lane15=%0d", res_vec[15*16 +: 16]);
    endtask

    task automatic test_bias_add();
        step(0, 2'd3, 1, '0, '0);
        step(0, 2'd0, 0, splat(16'd4096), splat(16'd8192));
        step(0, 2'd0, 0, splat(16'd4096), splat(16'hF000));
        step(0, 2'd0, 0, '0, '0);
        cmp_count++;
        if (res_vec !== splat(16'd4096)) begin
            err_count++;
            $display("FAIL bias_mac: got %h want %h", res_vec, splat(16'd4096));
        end
        step(0, 2'd3, 1, '0, '0);
        step(0, 2'd0, 0, splat(16'd4096), splat(16'd8192));
        step(0, 2'd2, 0, splat(16'hF800), rand_vec());
        step(0, 2'd0, 0, '0, '0);
        cmp_count++;
        if (res_vec !== splat(16'd6144)) begin
            err_count++;
            $display("FAIL bias_add: got %h want %h", res_vec, splat(16'd6144));
        end
        $display("test_bias_add lane0=%0d", res_vec[15:0]);
    endtask

    task automatic test_saturation();
        logic [L*16-1:0] av, bv;
        av = '0; bv = '0;
        av[15:0] = 16'h7FFF; bv[15:0] = 16'h7FFF;
        av[31:16] = 16'h8000; bv[31:16] = 16'h7FFF;
        step(0, 2'd3, 1, '0, '0);
        step(0, 2'd1, 0, av, bv);
        step(0, 2'd3, 0, '0, '0);
        cmp_count++;
`ifdef PE_SATURATE_EN
        if (res_vec[15:0] !== 16'h7FFF) begin
            err_count++;
            $display("FAIL sat_lane0: got %h want 7fff", res_vec[15:0]);
        end
`else
        if (res_vec[15:0] !== 16'hFFF0) begin
            err_count++;
            $display("FAIL sat_lane0: got %h want fff0", res_vec[15:0]);
        end
`endif
        cmp_count++;
        if (res_vec !== exp_res_vec()) begin
            err_count++;
            $display("FAIL sat_vec: got %h want %h", res_vec, exp_res_vec());
        end
        cmp_count++;
        if (ovf_vec !== 16'h0003) begin
            err_count++;
            $display("FAIL sat_ovf: got %h want 0003", ovf_vec);
        end
        step(0, 2'd3, 1, '0, '0);
        step(0, 2'd3, 0, '0, '0);
        cmp_count++;
        if (ovf_vec[0] !== 1'b0 || res_vec !== '0) begin
            err_count++;
            $display("FAIL sat_clear: got ovf %h res %h want 0 0", ovf_vec, res_vec);
        end
        // Random large products on every lane.
        step(0, 2'd1, 0, rand_vec(), rand_vec());
        step(0, 2'd3, 0, '0, '0);
        cmp_count++;
        if (res_vec !== exp_res_vec() || ovf_vec !== exp_ovf_vec()) begin
            err_count++;
            $display("FAIL sat_random: got %h/%h want %h/%h", res_vec, ovf_vec, exp_res_vec(), exp_ovf_vec());
        end
        $display("test_saturation ovf=%h", ovf_vec);
    endtask

    task automatic test_clear_priority();
        step(0, 2'd3, 1, '0, '0);
        step(0, 2'd0, 0, splat(16'd4096), splat(16'd4096));
        step(0, 2'd0, 0, '0, '0);
        cmp_count++;
        if (res_vec !== splat(16'd4096)) begin
            err_count++;
            $display("FAIL clrpri_pre: got %h want %h", res_vec, splat(16'd4096));
        end
        step(0, 2'd0, 1, splat(16'd4096), splat(16'd4096));
        for (int i = 0; i < 3; i++) begin
            step(0, 2'd3, 0, splat(16'h7FFF), splat(16'h7FFF));
            cmp_count++;
            if (res_vec !== '0) begin
                err_count++;
                $display("FAIL clrpri_hold[%0d]: got %h want 0", i, res_vec);
            end
        end
        $display("test_clear_priority done");
    endtask

    task automatic test_reset_mid();
        step(0, 2'd3, 1, '0, '0);
        step(0, 2'd0, 0, splat(16'd4096), splat(16'd4096));
        step(0, 2'd0, 0, splat(16'd4096), splat(16'd4096));
        step(1, 2'd0, 0, splat(16'd4096), splat(16'd4096));
        cmp_count++;
        if (res_vec !== '0) begin
            err_count++;
            $display("FAIL rstmid_zero: got %h want 0", res_vec);
        end
        step(0, 2'd0, 0, splat(16'd4096), splat(16'd4096));
        step(0, 2'd0, 0, splat(16'd4096), splat(16'd4096));
        step(0, 2'd0, 0, '0, '0);
        cmp_count++;
        if (res_vec !== splat(16'd8192)) begin
            err_count++;
            $display("FAIL rstmid_accum: got %h want %h", res_vec, splat(16'd8192));
        end
        $display("test_reset_mid lane0=%0d", res_vec[15:0]);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            step(0, 2'($urandom), ($urandom_range(0, 7) == 0), rand_vec(), rand_vec());
            cmp_count++;
            if (res_vec !== exp_res_vec() || ovf_vec !== exp_ovf_vec()) begin
                err_count++;
                $display("FAIL b2b[%0d]: got %h/%h want %h/%h", i, res_vec, ovf_vec, exp_res_vec(), exp_ovf_vec());
            end
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        reset = 1; mode = 2'd3; clr = 0; a_vec = '0; b_vec = '0;
        m_mode = 3; m_clr = 0;
        for (int k = 0; k < L; k++) begin
            m_p[k] = 0; m_ea[k] = 0; m_acc[k] = 0; m_ovf[k] = 0;
        end
        test_reset();
        test_accumulation();
        test_bias_add();
        test_saturation();
        test_clear_priority();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
